// File: rtl/romulus_config_pkg.sv
// rtl/romulus_config_pkg.sv - shared constants, FSM encodings and rho G-byte function
package romulus_config_pkg;

  localparam int STATE_W = 128;

  // FSM encodings
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ABSORB = 1'b1;

  // Number of bus beats needed to move one full 128-bit block
  function automatic int beats_of(input int busw);
    return STATE_W / busw;
  endfunction

  // Romulus rho G applied to one byte; linear over XOR
  function automatic logic [7:0] rho_g(input logic [7:0] b);
    return {b[0] ^ b[7], b[7:1]};
  endfunction

endpackage

// File: rtl/romulus_rho_beat.sv
// rtl/romulus_rho_beat.sv - combinational per-share G, XOR tree, pdo and effective input beat
module romulus_rho_beat
  import romulus_config_pkg::*;
#(
  parameter int SHARES = 2,
  parameter int BUSW   = 32
) (
  input  logic [SHARES*BUSW-1:0] i_tops,
  input  logic [BUSW-1:0]        i_pdi,
  input  logic [BUSW/8-1:0]      i_decrypt,
  output logic [BUSW-1:0]        o_pdo,
  output logic [BUSW-1:0]        o_pdi_eff
);

  logic [BUSW-1:0] w_gx;
  logic [BUSW-1:0] w_pdo;

  // G is linear, so each share is transformed separately and only the results are combined
  always_comb begin
    w_gx = '0;
    for (int s = 0; s < SHARES; s++) begin
      for (int k = 0; k < BUSW / 8; k++) begin
        w_gx[8*k +: 8] = w_gx[8*k +: 8] ^ rho_g(i_tops[s*BUSW + 8*k +: 8]);
      end
    end
  end

  assign w_pdo = i_pdi ^ w_gx;
  assign o_pdo = w_pdo;

  // Per-byte choice between the ciphertext-side and plaintext-side byte
  always_comb begin
    o_pdi_eff = '0;
    for (int k = 0; k < BUSW / 8; k++) begin
      o_pdi_eff[8*k +: 8] = i_decrypt[k] ? w_pdo[8*k +: 8] : i_pdi[8*k +: 8];
    end
  end

endmodule

// File: rtl/romulus_state_shares_seq.sv
// rtl/romulus_state_shares_seq.sv - masked Romulus state register with beat-wise rho absorb
module romulus_state_shares_seq
  import romulus_config_pkg::*;
#(
  parameter int SHARES = 2,
  parameter int BUSW   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    zeroize,
  input  logic                    absorb_start,
  input  logic                    iv,
  input  logic [BUSW/8-1:0]       decrypt,
  input  logic [BUSW-1:0]         pdi,
  input  logic                    pdi_valid,
  output logic                    pdi_ready,
  output logic [BUSW-1:0]         pdo,
  output logic                    pdo_valid,
  output logic                    block_done,
  output logic                    busy,
  input  logic                    tbc_en,
  input  logic [SHARES-1:0]       tbc_share_en,
  input  logic [128*SHARES-1:0]   state_i,
  output logic [128*SHARES-1:0]   state_o
);

  localparam int BEATS = beats_of(BUSW);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [0:0]              r_state;
  logic [CW-1:0]           r_beat_cnt;
  logic                    r_block_done;
  logic                    w_clear;
  logic                    w_accept;
  logic                    w_tbc_go;
  logic [SHARES-1:0]       w_sel;
  logic [SHARES*BUSW-1:0]  w_tops;
  logic [BUSW-1:0]         w_pdo;
  logic [BUSW-1:0]         w_pdi_eff;

  assign w_clear    = rst | zeroize;
  assign pdi_ready  = (r_state == ST_ABSORB);
  assign w_accept   = pdi_valid & pdi_ready;
  assign pdo_valid  = w_accept;
  assign busy       = (r_state != ST_IDLE);
  assign block_done = r_block_done;
  assign pdo        = w_pdo;
  assign w_tbc_go   = (r_state == ST_IDLE) & tbc_en & ~absorb_start;

  // Reduce the share-select mask to the lowest set bit
  always_comb begin
    logic found;
    found = 1'b0;
    w_sel = '0;
    for (int j = 0; j < SHARES; j++) begin
      if (tbc_share_en[j] && !found) begin
        w_sel[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // FSM, beat counter and block_done pulse; clear aborts without a done pulse
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state      <= ST_IDLE;
      r_beat_cnt   <= '0;
      r_block_done <= 1'b0;
    end else begin
      r_block_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_beat_cnt <= '0;
          if (absorb_start) r_state <= ST_ABSORB;
        end
        default: begin
          if (w_accept) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_state      <= ST_IDLE;
              r_beat_cnt   <= '0;
              r_block_done <= 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  romulus_rho_beat #(
    .SHARES (SHARES),
    .BUSW   (BUSW)
  ) u_rho_beat (
    .i_tops    (w_tops),
    .i_pdi     (pdi),
    .i_decrypt (decrypt),
    .o_pdo     (w_pdo),
    .o_pdi_eff (w_pdi_eff)
  );

  for (genvar i = 0; i < SHARES; i++) begin : g_share
    logic [127:0]    r_share;
    logic [BUSW-1:0] w_top;
    logic [BUSW-1:0] w_new;
    logic [127:0]    w_next;

    assign w_top = r_share[127 -: BUSW];
    assign w_tops[i*BUSW +: BUSW] = w_top;
    assign state_o[128*i +: 128]  = r_share;

    // Share 0 carries the data; the others just rotate so byte order is kept
    if (i == 0) begin : g_s0
      assign w_new = iv ? w_pdo : (w_pdi_eff ^ w_top);
    end else begin : g_si
      assign w_new = iv ? '0 : w_top;
    end

    if (BUSW == 128) begin : g_full
      assign w_next = w_new;
    end else begin : g_part
      assign w_next = {r_share[127-BUSW:0], w_new};
    end

    // Share register: clear, lockstep shift on accepted beat, or tbc load in IDLE
    always_ff @(posedge clk) begin
      if (w_clear) begin
        r_share <= '0;
      end else if (w_accept) begin
        r_share <= w_next;
      end else if (w_tbc_go && w_sel[i]) begin
        r_share <= state_i[128*i +: 128];
      end
    end
  end

endmodule
